mem_stage: RTL and testbench

- Memory-access pipeline stage. Consumes the EX/MEM register outputs (control, ALU result, store data, destination register, branch target/zero) and runs the data-memory request/ready handshake.
- Resolves branch redirect (pcsrc) and stalls upstream while a memory access is outstanding.
- Owns the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory handshake, branch redirect, stall and the MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN suppresses misaligned accesses and adds the misaligned output.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  wb_ctl,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        zero,
    input  logic [31:0] EX_MEM_NPC,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2out,
    input  logic [4:0]  five_bit_muxout,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        bus_error,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misaligned,
`endif
    output logic [1:0]  mem_wb_ctl,
    output logic [31:0] mem_wb_read_data,
    output logic [31:0] mem_wb_alu_result,
    output logic [4:0]  mem_wb_rd
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_error_q, bus_error_d;
    logic [1:0]  mem_wb_ctl_q, mem_wb_ctl_d;
    logic [31:0] mem_wb_read_data_q, mem_wb_read_data_d;
    logic [31:0] mem_wb_alu_result_q, mem_wb_alu_result_d;
    logic [4:0]  mem_wb_rd_q, mem_wb_rd_d;

    logic access;
    logic misalign_hit;
    logic mem_access;
    logic req_c;
    logic stall_c;
    logic capture;
    logic bubble;

    assign access = memread | memwrite;

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    assign misalign_hit = access & (alu_result[1:0] != 2'b00);
    assign misaligned_d = (state_q == IDLE) & misalign_hit;
    assign misaligned   = misaligned_q;
`else
    assign misalign_hit = 1'b0;
`endif

    assign mem_access = access & ~misalign_hit;

    assign pcsrc         = branch & zero;
    assign branch_target = EX_MEM_NPC;
    assign dmem_we       = memwrite;
    assign dmem_addr     = alu_result & 32'hFFFF_FFFC;
    assign dmem_wdata    = rdata2out;

    // Reset overrides the handshake so nothing is requested or held while the core restarts.
    assign dmem_req = reset_n & req_c;
    assign stall    = reset_n & stall_c;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_error_d = 1'b0;
        req_c       = mem_access;
        stall_c     = 1'b0;
        capture     = 1'b0;
        bubble      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!mem_access) begin
                    capture = ~misalign_hit;
                    bubble  = misalign_hit;
                end else if (dmem_ready) begin
                    capture = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    bubble  = 1'b1;
                    state_d = WAIT;
                    cnt_d   = 8'd0;
                end
            end
            WAIT: begin
                if (!mem_access) begin
                    bubble  = 1'b1;
                    state_d = IDLE;
                end else if (dmem_ready) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort cycle: withdraw the request and let the pipeline move on with a bubble.
                    req_c       = 1'b0;
                    bubble      = 1'b1;
                    bus_error_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    stall_c = 1'b1;
                    bubble  = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                bubble  = 1'b1;
            end
        endcase
    end

    always_comb begin
        mem_wb_ctl_d        = mem_wb_ctl_q;
        mem_wb_read_data_d  = mem_wb_read_data_q;
        mem_wb_alu_result_d = mem_wb_alu_result_q;
        mem_wb_rd_d         = mem_wb_rd_q;

        if (capture) begin
            mem_wb_ctl_d        = wb_ctl;
            mem_wb_alu_result_d = alu_result;
            mem_wb_rd_d         = five_bit_muxout;
            if (mem_access && memread) begin
                mem_wb_read_data_d = dmem_rdata;
            end
        end else if (bubble) begin
            mem_wb_ctl_d = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q             <= IDLE;
            cnt_q               <= 8'd0;
            bus_error_q         <= 1'b0;
            mem_wb_ctl_q        <= 2'b00;
            mem_wb_read_data_q  <= 32'd0;
            mem_wb_alu_result_q <= 32'd0;
            mem_wb_rd_q         <= 5'd0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            bus_error_q         <= bus_error_d;
            mem_wb_ctl_q        <= mem_wb_ctl_d;
            mem_wb_read_data_q  <= mem_wb_read_data_d;
            mem_wb_alu_result_q <= mem_wb_alu_result_d;
            mem_wb_rd_q         <= mem_wb_rd_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`endif

    assign bus_error         = bus_error_q;
    assign mem_wb_ctl        = mem_wb_ctl_q;
    assign mem_wb_read_data  = mem_wb_read_data_q;
    assign mem_wb_alu_result = mem_wb_alu_result_q;
    assign mem_wb_rd         = mem_wb_rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage, built with TIMEOUT=4.
// Also exercises the misaligned path when MEM_ALIGN_CHECK_EN is defined.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  wb_ctl;
    logic        branch, memread, memwrite, zero;
    logic [31:0] EX_MEM_NPC, alu_result, rdata2out;
    logic [4:0]  five_bit_muxout;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        stall, pcsrc;
    logic [31:0] branch_target;
    logic        bus_error;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif
    logic [1:0]  mem_wb_ctl;
    logic [31:0] mem_wb_read_data, mem_wb_alu_result;
    logic [4:0]  mem_wb_rd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .wb_ctl           (wb_ctl),
        .branch           (branch),
        .memread          (memread),
        .memwrite         (memwrite),
        .zero             (zero),
        .EX_MEM_NPC       (EX_MEM_NPC),
        .alu_result       (alu_result),
        .rdata2out        (rdata2out),
        .five_bit_muxout  (five_bit_muxout),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ready       (dmem_ready),
        .stall            (stall),
        .pcsrc            (pcsrc),
        .branch_target    (branch_target),
        .bus_error        (bus_error),
`ifdef MEM_ALIGN_CHECK_EN
        .misaligned       (misaligned),
`endif
        .mem_wb_ctl       (mem_wb_ctl),
        .mem_wb_read_data (mem_wb_read_data),
        .mem_wb_alu_result(mem_wb_alu_result),
        .mem_wb_rd        (mem_wb_rd)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd_en, input logic wr_en, input logic [1:0] ctl,
                                 input logic [31:0] addr, input logic [4:0] rd, input logic ready);
        memread         = rd_en;
        memwrite        = wr_en;
        wb_ctl          = ctl;
        alu_result      = addr;
        five_bit_muxout = rd;
        dmem_ready      = ready;
    endtask

    // Advance one rising edge and land 2 time units after it, away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n    = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        EX_MEM_NPC = 32'd0;
        rdata2out  = 32'd0;
        dmem_rdata = 32'd0;
        applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 5'd0, 1'b0);
        tick();
        tick();
        checkOutput("reset_mem_wb_ctl", 32'(mem_wb_ctl), 32'h0);
        checkOutput("reset_mem_wb_alu", mem_wb_alu_result, 32'h0);
        checkOutput("reset_bus_error", 32'(bus_error), 32'h0);
        checkOutput("reset_stall", 32'(stall), 32'h0);
        reset_n = 1'b1;

        // No-access op
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h0000_00A5, 5'd5, 1'b0);
        #1;
        checkOutput("noacc_stall", 32'(stall), 32'h0);
        checkOutput("noacc_req", 32'(dmem_req), 32'h0);
        tick();
        checkOutput("noacc_ctl", 32'(mem_wb_ctl), 32'h2);
        checkOutput("noacc_alu", mem_wb_alu_result, 32'hA5);
        checkOutput("noacc_rd", 32'(mem_wb_rd), 32'd5);
        checkOutput("noacc_rdata_hold", mem_wb_read_data, 32'h0);

        // Zero-wait load
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0000_0100, 5'd7, 1'b1);
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("zw_req", 32'(dmem_req), 32'h1);
        checkOutput("zw_we", 32'(dmem_we), 32'h0);
        checkOutput("zw_addr", dmem_addr, 32'h100);
        checkOutput("zw_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("zw_rdata", mem_wb_read_data, 32'hDEAD_BEEF);
        checkOutput("zw_ctl", 32'(mem_wb_ctl), 32'h3);
        checkOutput("zw_rd", 32'(mem_wb_rd), 32'd7);

        // Three-wait store, issued back to back with the load
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h0000_0204, 5'd9, 1'b0);
        rdata2out  = 32'h0000_1234;
        dmem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("st_stall", 32'(stall), 32'h1);
            checkOutput("st_req", 32'(dmem_req), 32'h1);
            checkOutput("st_we", 32'(dmem_we), 32'h1);
            checkOutput("st_addr", dmem_addr, 32'h204);
            checkOutput("st_wdata", dmem_wdata, 32'h1234);
            tick();
            checkOutput("st_bubble_ctl", 32'(mem_wb_ctl), 32'h0);
            checkOutput("st_bubble_alu_hold", mem_wb_alu_result, 32'h100);
        end
        dmem_ready = 1'b1;
        #1;
        checkOutput("st_done_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("st_ctl", 32'(mem_wb_ctl), 32'h1);
        checkOutput("st_alu", mem_wb_alu_result, 32'h204);
        checkOutput("st_rdata_hold", mem_wb_read_data, 32'hDEAD_BEEF);

        // Timeout with TIMEOUT=4
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0000_0300, 5'd12, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("to_stall", 32'(stall), 32'h1);
            checkOutput("to_req", 32'(dmem_req), 32'h1);
            tick();
            checkOutput("to_bubble_ctl", 32'(mem_wb_ctl), 32'h0);
            checkOutput("to_no_buserr", 32'(bus_error), 32'h0);
        end
        #1;
        checkOutput("to_abort_req", 32'(dmem_req), 32'h0);
        checkOutput("to_abort_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("to_buserr", 32'(bus_error), 32'h1);
        checkOutput("to_abort_ctl", 32'(mem_wb_ctl), 32'h0);
        checkOutput("to_abort_alu_hold", mem_wb_alu_result, 32'h204);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h0000_0044, 5'd3, 1'b0);
        tick();
        checkOutput("to_buserr_pulse", 32'(bus_error), 32'h0);
        checkOutput("to_idle_ctl", 32'(mem_wb_ctl), 32'h2);
        checkOutput("to_idle_alu", mem_wb_alu_result, 32'h44);

        // Branch resolution, combinational
        branch     = 1'b1;
        zero       = 1'b1;
        EX_MEM_NPC = 32'h0000_0040;
        #1;
        checkOutput("br_pcsrc", 32'(pcsrc), 32'h1);
        checkOutput("br_target", branch_target, 32'h40);
        zero = 1'b0;
        #1;
        checkOutput("br_not_taken", 32'(pcsrc), 32'h0);
        branch = 1'b0;
        tick();

        // Reset while a load is waiting
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0000_0500, 5'd8, 1'b0);
        #1;
        checkOutput("rst_pre_stall", 32'(stall), 32'h1);
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("rst_req_low", 32'(dmem_req), 32'h0);
        checkOutput("rst_stall_low", 32'(stall), 32'h0);
        tick();
        checkOutput("rst_ctl", 32'(mem_wb_ctl), 32'h0);
        checkOutput("rst_rdata", mem_wb_read_data, 32'h0);
        checkOutput("rst_alu", mem_wb_alu_result, 32'h0);
        checkOutput("rst_rd", 32'(mem_wb_rd), 32'h0);
        checkOutput("rst_buserr", 32'(bus_error), 32'h0);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0000_0600, 5'd6, 1'b1);
        dmem_rdata = 32'hCAFE_0001;
        #1;
        checkOutput("rst_idle_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("rst_idle_rdata", mem_wb_read_data, 32'hCAFE_0001);
        checkOutput("rst_idle_ctl", 32'(mem_wb_ctl), 32'h3);

`ifdef MEM_ALIGN_CHECK_EN
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0000_0102, 5'd2, 1'b1);
        #1;
        checkOutput("mis_req", 32'(dmem_req), 32'h0);
        checkOutput("mis_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("mis_flag", 32'(misaligned), 32'h1);
        checkOutput("mis_ctl", 32'(mem_wb_ctl), 32'h0);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h0000_0010, 5'd1, 1'b0);
        tick();
        checkOutput("mis_pulse", 32'(misaligned), 32'h0);
`else
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0000_010B, 5'd2, 1'b1);
        #1;
        checkOutput("align_req", 32'(dmem_req), 32'h1);
        checkOutput("align_addr", dmem_addr, 32'h108);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        failures++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
